// File: rtl/noc_frame_tx_pkg.sv
// Shared NoC link constants, packet layout and serializer state encoding.
// NOC_FRAME_TX_CHECKSUM_EN adds the checksum states to the state enum.
package noc_frame_tx_pkg;
  localparam int PAYLOAD_SIZE = 4;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  localparam logic [7:0] ESC_BYTE  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  typedef struct packed {
    logic [3:0]                x_dest;
    logic [3:0]                y_dest;
    logic [PAYLOAD_SIZE*8-1:0] payload;
  } packet_t;

  typedef enum logic [3:0] {
    IDLE,
    SOF,
    DEST,
    PAY,
    ESC2,
`ifdef NOC_FRAME_TX_CHECKSUM_EN
    CSUM,
    CSUM_ESC2,
`endif
    EOF,
    TERM
  } frame_tx_state_t;
endpackage

// File: rtl/noc_frame_tx_escaper.sv
// Byte stuffing helper: flags a byte that collides with flag/escape codes
// and supplies its XOR-ed substitute.
module noc_byte_escaper
  import noc_frame_tx_pkg::*;
(
  input  logic [7:0] b,
  output logic       needs_esc,
  output logic [7:0] esc_byte
);
  assign needs_esc = (b == FLAG_BYTE) || (b == ESC_BYTE);
  assign esc_byte  = b ^ ESC_XOR;
endmodule

// File: rtl/noc_frame_tx.sv
// Output-port frame serializer: pops one packet and emits 7E, dest, payload, 7E, 00.
// Define NOC_FRAME_TX_CHECKSUM_EN to append an escaped XOR checksum byte.
module noc_frame_tx
  import noc_frame_tx_pkg::*;
#(
  parameter int PAYLOAD_BYTES = PAYLOAD_SIZE,
  parameter int TERM_BYTES    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  packet_t    pkt_in,
  input  logic       pkt_valid,
  output logic       pkt_rd_en,
  output logic [7:0] out_byte,
  output logic       busy,
  output logic       frame_done
);
  localparam int SR_W  = (PAYLOAD_BYTES + 1) * 8;
  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PAYLOAD_BYTES + 1);
  localparam logic [1:0]       TERM_LAST = 2'(TERM_BYTES - 1);

  frame_tx_state_t   state, state_n;
  logic [SR_W-1:0]   sreg;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        tcnt, tcnt_n;
  logic              esc_pend, esc_n;
  logic [7:0]        byte_n;
  logic              shift, pop, fdone_n, next_item, emit_top;
  logic [7:0]        top, top_x;
  logic              top_esc;

  // {dest, payload} shifts out MSB first; top is always the next data byte
  assign top = sreg[SR_W-1 -: 8];

  noc_byte_escaper u_esc_data (.b(top), .needs_esc(top_esc), .esc_byte(top_x));

`ifdef NOC_FRAME_TX_CHECKSUM_EN
  logic [7:0] csum, csum_n, csum_x;
  logic       csum_esc;
  noc_byte_escaper u_esc_csum (.b(csum), .needs_esc(csum_esc), .esc_byte(csum_x));
`endif

  always_comb begin
    state_n   = state;
    byte_n    = IDLE_BYTE;
    shift     = 1'b0;
    esc_n     = 1'b0;
    pop       = 1'b0;
    fdone_n   = 1'b0;
    tcnt_n    = tcnt;
    next_item = 1'b0;
    emit_top  = 1'b0;
`ifdef NOC_FRAME_TX_CHECKSUM_EN
    csum_n    = csum;
`endif
    case (state)
      IDLE: if (pkt_valid) begin
        pop     = 1'b1;
        state_n = SOF;
        byte_n  = FLAG_BYTE;
      end
      SOF: begin
        state_n  = DEST;
        emit_top = 1'b1;
      end
      DEST, PAY: if (esc_pend) begin
        state_n = ESC2;
        byte_n  = top_x;
        shift   = 1'b1;
      end else begin
        next_item = 1'b1;
      end
      ESC2: next_item = 1'b1;
`ifdef NOC_FRAME_TX_CHECKSUM_EN
      CSUM: if (esc_pend) begin
        state_n = CSUM_ESC2;
        byte_n  = csum_x;
      end else begin
        state_n = EOF;
        byte_n  = FLAG_BYTE;
      end
      CSUM_ESC2: begin
        state_n = EOF;
        byte_n  = FLAG_BYTE;
      end
`endif
      EOF: begin
        state_n = TERM;
        tcnt_n  = 2'd0;
        fdone_n = (TERM_LAST == 2'd0);
      end
      TERM: if (tcnt == TERM_LAST) begin
        // Back-to-back frames: the next flag replaces the idle byte
        if (pkt_valid) begin
          pop     = 1'b1;
          state_n = SOF;
          byte_n  = FLAG_BYTE;
        end else begin
          state_n = IDLE;
        end
      end else begin
        tcnt_n  = tcnt + 2'd1;
        fdone_n = (tcnt_n == TERM_LAST);
      end
      default: state_n = IDLE;
    endcase

    if (next_item) begin
      if (cnt == LAST_CNT) begin
`ifdef NOC_FRAME_TX_CHECKSUM_EN
        state_n = CSUM;
        byte_n  = csum_esc ? ESC_BYTE : csum;
        esc_n   = csum_esc;
`else
        state_n = EOF;
        byte_n  = FLAG_BYTE;
`endif
      end else begin
        state_n  = PAY;
        emit_top = 1'b1;
      end
    end

    // An escaped byte stays at top until its second half goes out in ESC2
    if (emit_top) begin
      byte_n = top_esc ? ESC_BYTE : top;
      esc_n  = top_esc;
      shift  = !top_esc;
`ifdef NOC_FRAME_TX_CHECKSUM_EN
      csum_n = csum ^ top;
`endif
    end
  end

  assign pkt_rd_en = pop & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out_byte   <= IDLE_BYTE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      esc_pend   <= 1'b0;
      tcnt       <= 2'd0;
      cnt        <= '0;
      sreg       <= '0;
`ifdef NOC_FRAME_TX_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      state      <= state_n;
      out_byte   <= byte_n;
      busy       <= (state_n != IDLE);
      frame_done <= fdone_n;
      esc_pend   <= esc_n;
      tcnt       <= tcnt_n;
      if (pop) begin
        sreg <= {pkt_in.x_dest, pkt_in.y_dest, pkt_in.payload[PAYLOAD_BYTES*8-1:0]};
        cnt  <= '0;
      end else if (shift) begin
        sreg <= {sreg[SR_W-9:0], 8'h00};
        cnt  <= cnt + 1'b1;
      end
`ifdef NOC_FRAME_TX_CHECKSUM_EN
      csum <= pop ? 8'h00 : csum_n;
`endif
    end
  end
endmodule

// File: tb/tb_noc_frame_tx.sv
// Directed bench for noc_frame_tx: plain, escaped, back-to-back and reset-abort frames.
module tb_noc_frame_tx;
  import noc_frame_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  packet_t    pkt_in;
  logic       pkt_valid;
  logic       pkt_rd_en;
  logic [7:0] out_byte;
  logic       busy;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;
  int p0;

  noc_frame_tx dut (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .pkt_valid(pkt_valid),
    .pkt_rd_en(pkt_rd_en), .out_byte(out_byte), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (pkt_rd_en) pops <= pops + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_pkt(input string tag, input logic [7:0] d, input logic [31:0] p);
    pkt_in    = packet_t'({d, p});
    pkt_valid = 1'b1;
    #1;
    check({tag, ":rd_en"}, 32'(pkt_rd_en), 32'd1);
    step();
  endtask

  // v holds the expected link bytes right-aligned, first byte most significant
  task automatic stream(input string tag, input logic [127:0] v, input int n, input bit chain);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s:byte%0d", tag, i), 32'(out_byte), 32'(v[8*(n-1-i) +: 8]));
      check($sformatf("%s:busy%0d", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s:done%0d", tag, i), 32'(frame_done), 32'(i == n-1));
      check($sformatf("%s:rd%0d", tag, i), 32'(pkt_rd_en), 32'(chain && i == n-1));
      step();
    end
    if (!chain) begin
      check({tag, ":idle_byte"}, 32'(out_byte), 32'h00);
      check({tag, ":idle_busy"}, 32'(busy), 32'd0);
      check({tag, ":idle_done"}, 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    pkt_valid = 1'b0;
    pkt_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:out", 32'(out_byte), 32'h00);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(frame_done), 32'd0);
    pkt_valid = 1'b1;
    #1;
    check("rst:rd_gated", 32'(pkt_rd_en), 32'd0);
    pkt_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
    check("idle:out", 32'(out_byte), 32'h00);

    p0 = pops;
    pop_pkt("plain", 8'h12, 32'hDEADBEEF);
    pkt_valid = 1'b0;
`ifdef NOC_FRAME_TX_CHECKSUM_EN
    stream("plain", 128'h7E12DEADBEEF307E00, 9, 1'b0);
`else
    stream("plain", 128'h7E12DEADBEEF7E00, 8, 1'b0);
`endif
    check("plain:pops", 32'(pops - p0), 32'd1);

    pop_pkt("esc", 8'h21, 32'h7E7D0011);
    pkt_valid = 1'b0;
`ifdef NOC_FRAME_TX_CHECKSUM_EN
    stream("esc", 128'h7E217D5E7D5D0011337E00, 11, 1'b0);
`else
    stream("esc", 128'h7E217D5E7D5D00117E00, 10, 1'b0);
`endif

    pop_pkt("escdest", 8'h7D, 32'h00000000);
    pkt_valid = 1'b0;
`ifdef NOC_FRAME_TX_CHECKSUM_EN
    stream("escdest", 128'h7E7D5D000000007D5D7E00, 11, 1'b0);
`else
    stream("escdest", 128'h7E7D5D000000007E00, 9, 1'b0);
`endif

    p0 = pops;
    pop_pkt("b2b", 8'h12, 32'hDEADBEEF);
    pkt_in = packet_t'({8'h10, 32'hCAFEBABE});
`ifdef NOC_FRAME_TX_CHECKSUM_EN
    stream("b2b_a", 128'h7E12DEADBEEF307E00, 9, 1'b1);
    pkt_valid = 1'b0;
    stream("b2b_b", 128'h7E10CAFEBABE207E00, 9, 1'b0);
`else
    stream("b2b_a", 128'h7E12DEADBEEF7E00, 8, 1'b1);
    pkt_valid = 1'b0;
    stream("b2b_b", 128'h7E10CAFEBABE7E00, 8, 1'b0);
`endif
    check("b2b:pops", 32'(pops - p0), 32'd2);

    pop_pkt("abort", 8'h12, 32'hDEADBEEF);
    pkt_valid = 1'b0;
    check("abort:b0", 32'(out_byte), 32'h7E); step();
    check("abort:b1", 32'(out_byte), 32'h12); step();
    check("abort:b2", 32'(out_byte), 32'hDE); step();
    check("abort:b3", 32'(out_byte), 32'hAD);
    #2 rst = 1'b0;
    #1;
    check("abort:out", 32'(out_byte), 32'h00);
    check("abort:busy", 32'(busy), 32'd0);
    pkt_valid = 1'b1;
    #1;
    check("abort:rd_gated", 32'(pkt_rd_en), 32'd0);
    pkt_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post:out%0d", i), 32'(out_byte), 32'h00);
      check($sformatf("post:busy%0d", i), 32'(busy), 32'd0);
    end
    check("post:pops", 32'(pops - p0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
